// File: rtl/instr_decode_stage.sv
// RV32I/RV64I decode stage: splits fields, builds the sign-extended immediate and
// classifies the format, behind a valid/ready handshake with a one-entry skid register.
module instr_decode_stage #(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [31:0]         out_instr,
  output logic [6:0]          opcode,
  output logic [4:0]          rd,
  output logic [2:0]          funct3,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [6:0]          funct7,
  output logic [XLEN-1:0]     imm,
  output logic [2:0]          fmt,
  output logic                illegal
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  function automatic logic [2:0] decode_fmt(input logic [31:0] instr);
    logic [2:0] f;
    f = FMT_ILL;
    case (instr[6:0])
      7'b0110011: f = FMT_R;
      7'b0010011,
      7'b0000011,
      7'b1100111,
      7'b1110011: f = FMT_I;
      7'b0100011: f = FMT_S;
      7'b1100011: f = FMT_B;
      7'b0110111,
      7'b0010111: f = FMT_U;
      7'b1101111: f = FMT_J;
      7'b0011011: f = (XLEN == 64) ? FMT_I : FMT_ILL;
      7'b0111011: f = (XLEN == 64) ? FMT_R : FMT_ILL;
      default:    f = FMT_ILL;
    endcase
    if (instr[1:0] != 2'b11) f = FMT_ILL;
    return f;
  endfunction

  // Every base immediate is first built as a 32-bit signed value, then widened to XLEN.
  function automatic logic [XLEN-1:0] decode_imm(input logic [31:0] instr,
                                                 input logic [2:0]  f);
    logic [31:0] imm32;
    imm32 = '0;
    case (f)
      FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      FMT_U: imm32 = {instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    return XLEN'($signed(imm32));
  endfunction

  logic                skid_valid;
  logic [31:0]         skid_instr;
  logic [PC_WIDTH-1:0] skid_pc;
  logic [31:0]         instr_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [XLEN-1:0]     imm_q;
  logic [2:0]          fmt_q;
  logic                valid_q;

  logic                in_fire;
  logic                out_free;
  logic [31:0]         load_instr;
  logic [PC_WIDTH-1:0] load_pc;
  logic [2:0]          load_fmt;
  logic [XLEN-1:0]     load_imm;

  assign in_ready = !skid_valid;
  assign in_fire  = in_valid && !skid_valid && !flush;
  assign out_free = !valid_q || out_ready;

  // A full skid always wins the output slot; in that case in_ready is low anyway.
  assign load_instr = skid_valid ? skid_instr : in_instr;
  assign load_pc    = skid_valid ? skid_pc    : in_pc;
  assign load_fmt   = decode_fmt(load_instr);
  assign load_imm   = decode_imm(load_instr, load_fmt);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
      instr_q    <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      fmt_q      <= FMT_R;
    end else if (flush) begin
      valid_q    <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid || in_fire) begin
        valid_q    <= 1'b1;
        skid_valid <= 1'b0;
        instr_q    <= load_instr;
        pc_q       <= load_pc;
        imm_q      <= load_imm;
        fmt_q      <= load_fmt;
      end else begin
        valid_q    <= 1'b0;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_instr <= in_instr;
      skid_pc    <= in_pc;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_instr = instr_q;
  assign opcode    = instr_q[6:0];
  assign rd        = instr_q[11:7];
  assign funct3    = instr_q[14:12];
  assign rs1       = instr_q[19:15];
  assign rs2       = instr_q[24:20];
  assign funct7    = instr_q[31:25];
  assign imm       = imm_q;
  assign fmt       = fmt_q;
  assign illegal   = (fmt_q == FMT_ILL);

endmodule

// File: tb/tb_instr_decode_stage.sv
// Drives one RV32 and one RV64 decode stage in lockstep and compares both
// against a queue-based model of the stage contents and the decode rules.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        a_in_ready, a_out_valid, a_illegal;
  logic [31:0] a_out_pc, a_out_instr, a_imm;
  logic [6:0]  a_opcode, a_funct7;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [2:0]  a_funct3, a_fmt;

  logic        b_in_ready, b_out_valid, b_illegal;
  logic [31:0] b_out_pc, b_out_instr;
  logic [63:0] b_imm;
  logic [6:0]  b_opcode, b_funct7;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_funct3, b_fmt;

  instr_decode_stage #(.XLEN(32), .PC_WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(a_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
    .out_instr(a_out_instr), .opcode(a_opcode), .rd(a_rd), .funct3(a_funct3),
    .rs1(a_rs1), .rs2(a_rs2), .funct7(a_funct7), .imm(a_imm), .fmt(a_fmt),
    .illegal(a_illegal));

  instr_decode_stage #(.XLEN(64), .PC_WIDTH(32)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
    .out_instr(b_out_instr), .opcode(b_opcode), .rd(b_rd), .funct3(b_funct3),
    .rs1(b_rs1), .rs2(b_rs2), .funct7(b_funct7), .imm(b_imm), .fmt(b_fmt),
    .illegal(b_illegal));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } rec_t;

  rec_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int modelFmt(input logic [31:0] instr, input bit is64);
    int f;
    logic [6:0] op;
    op = instr[6:0];
    if      (op == 7'h33) f = 0;
    else if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73) f = 1;
    else if (op == 7'h23) f = 2;
    else if (op == 7'h63) f = 3;
    else if (op == 7'h37 || op == 7'h17) f = 4;
    else if (op == 7'h6F) f = 5;
    else if (is64 && op == 7'h1B) f = 1;
    else if (is64 && op == 7'h3B) f = 0;
    else f = 7;
    return f;
  endfunction

  // Immediate rebuilt as a signed integer so widening does the sign extension.
  function automatic longint modelImm(input logic [31:0] instr, input int f);
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic signed [31:0] u32;
    logic signed [20:0] j21;
    longint r;
    r = 0;
    case (f)
      1: begin i12 = instr[31:20]; r = i12; end
      2: begin i12 = {instr[31:25], instr[11:7]}; r = i12; end
      3: begin b13 = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}; r = b13; end
      4: begin u32 = {instr[31:12], 12'b0}; r = u32; end
      5: begin j21 = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}; r = j21; end
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic verifyCycle(input logic wasReset);
    rec_t r;
    int   f32, f64;
    longint i32v, i64v;
    checkOutput("out_valid32", a_out_valid, q.size() > 0);
    checkOutput("out_valid64", b_out_valid, q.size() > 0);
    checkOutput("in_ready32", a_in_ready, q.size() < 2);
    checkOutput("in_ready64", b_in_ready, q.size() < 2);
    if (q.size() > 0) begin
      r    = q[0];
      f32  = modelFmt(r.instr, 1'b0);
      f64  = modelFmt(r.instr, 1'b1);
      i32v = modelImm(r.instr, f32);
      i64v = modelImm(r.instr, f64);
      checkOutput("fields32", {a_funct7, a_rs2, a_rs1, a_funct3, a_rd, a_opcode}, r.instr);
      checkOutput("fields64", {b_funct7, b_rs2, b_rs1, b_funct3, b_rd, b_opcode}, r.instr);
      checkOutput("out_instr32", a_out_instr, r.instr);
      checkOutput("out_pc32", a_out_pc, r.pc);
      checkOutput("out_pc64", b_out_pc, r.pc);
      checkOutput("imm32", a_imm, i32v[31:0]);
      checkOutput("imm64", b_imm, i64v);
      checkOutput("fmt32", a_fmt, f32[2:0]);
      checkOutput("fmt64", b_fmt, f64[2:0]);
      checkOutput("illegal32", a_illegal, f32 == 7);
      checkOutput("illegal64", b_illegal, f64 == 7);
    end
    if (wasReset) begin
      checkOutput("rst_data32", {a_out_pc, a_out_instr, a_imm, a_fmt, a_illegal}, 64'd0);
      checkOutput("rst_data64", {b_out_pc, b_out_instr, b_fmt, b_illegal}, 64'd0);
      checkOutput("rst_imm64", b_imm, 64'd0);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [31:0] ins,
                               input logic [31:0] pc, input logic ordy,
                               input logic fl, input logic rst);
    bit canTake;
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    @(posedge clk);
    if (rst || fl) begin
      q.delete();
    end else begin
      canTake = q.size() < 2;
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (iv && canTake) q.push_back('{instr: ins, pc: pc});
    end
    #1;
    verifyCycle(rst);
  endtask

  // Loads one word into an empty stage and checks the decode against literal answers.
  task automatic directedDecode(input logic [31:0] ins, input logic [31:0] eImm32,
                                input logic [63:0] eImm64, input logic [2:0] eFmt32,
                                input logic [2:0] eFmt64);
    applyStimulus(1'b1, ins, 32'h1000, 1'b1, 1'b0, 1'b0);
    checkOutput("dir_valid", a_out_valid, 1'b1);
    checkOutput("dir_imm32", a_imm, eImm32);
    checkOutput("dir_imm64", b_imm, eImm64);
    checkOutput("dir_fmt32", a_fmt, eFmt32);
    checkOutput("dir_fmt64", b_fmt, eFmt64);
    checkOutput("dir_illegal32", a_illegal, eFmt32 == 3'd7);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  logic [6:0] legalOps [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23,
                                7'h63, 7'h37, 7'h17, 7'h6F, 7'h1B};

  initial begin
    logic [31:0] w;
    applyStimulus(1'b1, 32'hFFF10093, 32'h0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

    directedDecode(32'hFFF10093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 3'd1);
    directedDecode(32'h00532423, 32'h8, 64'h8, 3'd2, 3'd2);
    directedDecode(32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 3'd3);
    directedDecode(32'h001000EF, 32'h800, 64'h800, 3'd5, 3'd5);
    directedDecode(32'h123451B7, 32'h12345000, 64'h12345000, 3'd4, 3'd4);
    directedDecode(32'h00000000, 32'h0, 64'h0, 3'd7, 3'd7);
    directedDecode(32'h0000009B, 32'h0, 64'h0, 3'd7, 3'd1);

    // Backpressure: A, B held, C offered until it gets in.
    applyStimulus(1'b1, 32'h00100093, 32'h100, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00200113, 32'h104, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00300193, 32'h108, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00300193, 32'h108, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00300193, 32'h108, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00300193, 32'h108, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_c_pc", a_out_pc, 32'h108);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush with A in output, B in skid, C offered.
    applyStimulus(1'b1, 32'h00400213, 32'h200, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00500293, 32'h204, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00600313, 32'h208, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_valid", a_out_valid, 1'b0);
    applyStimulus(1'b1, 32'h00700393, 32'h20C, 1'b1, 1'b0, 1'b0);
    checkOutput("flush_d_pc", a_out_pc, 32'h20C);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Reset with two records held, then one post-reset record.
    applyStimulus(1'b1, 32'hFFF10093, 32'h300, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00532423, 32'h304, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h123451B7, 32'h308, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h001000EF, 32'h30C, 1'b1, 1'b0, 1'b0);
    checkOutput("post_rst_pc", a_out_pc, 32'h30C);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 600; n++) begin
      w = $urandom;
      if ($urandom_range(0, 9) < 8) w[6:0] = legalOps[$urandom_range(0, 10)];
      if ($urandom_range(0, 19) == 0) w[6:0] = 7'h3B;
      applyStimulus($urandom_range(0, 3) != 0, w, $urandom,
                    $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0,
                    $urandom_range(0, 59) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Registered, parametrised RISC-V RV32I/RV64I decode stage that follows the fetch stage.
- Splits each instruction into its fields, generates the sign-extended immediate for every base format, classifies the format and flags illegal encodings.
- Uses a valid/ready handshake with a 2-entry skid buffer for full throughput under backpressure.
- Supports a flush for branch redirect.

Parameters:
XLEN, 32, datapath width (32 or 64); immediate sign-extension width; 64 also enables the OP-IMM-32 and OP-32 opcodes.
PC_WIDTH, 32, width of the program-counter sideband carried with each instruction.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
flush  input  1  discard all held and incoming instructions this cycle
in_valid  input  1  instruction/pc valid
in_ready  output  1  stage can accept
in_instr  input  32  raw instruction word
in_pc  input  PC_WIDTH  instruction address
out_valid  output  1  decoded record valid
out_ready  input  1  downstream accepts
out_pc  output  PC_WIDTH  pc of record
out_instr  output  32  raw word, passthrough
opcode  output  7  instr[6:0]
rd  output  5  instr[11:7]
funct3  output  3  instr[14:12]
rs1  output  5  instr[19:15]
rs2  output  5  instr[24:20]
funct7  output  7  instr[31:25]
imm  output  XLEN  sign-extended immediate
fmt  output  3  0=R 1=I 2=S 3=B 4=U 5=J 7=ILLEGAL
illegal  output  1  fmt==7

Behaviour:
- Transfer on the input side: in_valid & in_ready. Transfer on the output side: out_valid & out_ready.
- Decode is combinational on in_instr and is captured into the output register. Latency is 1 cycle from input transfer to out_valid.
- Storage is the output register plus one skid register.
  - in_ready = !skid_valid (registered; no combinational path from out_ready).
  - Input transfer while the output register is empty, or is being drained this cycle, loads the output register.
  - Input transfer while the output register is held loads the skid register.
  - When the output drains and the skid is full, the skid moves to the output register and the skid clears.
  - Strict in-order delivery; no record is dropped or duplicated.
- Registered outputs hold stable while out_valid & !out_ready.
- Field extraction: opcode, rd, funct3, rs1, rs2 and funct7 are always the raw bit slices, regardless of format.
- Format by opcode:
  - R: 0110011.
  - I: 0010011, 0000011, 1100111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - XLEN==64 only: 0011011 is I, 0111011 is R.
  - Any other opcode, or instr[1:0] != 11, gives fmt=7 and illegal=1.
- Immediate, sign bit instr[31] extended to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R and ILLEGAL: imm=0.
- Illegal instructions are still delivered with out_valid; the stage does not stall or trap.
- flush = 1:
  - Next cycle, out_valid=0 and skid_valid=0.
  - An input offered in the same cycle is discarded, even if in_ready=1.
  - flush has priority over all transfers.
- reset = 1:
  - Next edge: out_valid=0, skid_valid=0, in_ready=1.
  - All data outputs are 0; fmt=0 and illegal=0.
  - in_valid is ignored while reset is high.
  - Reset mid-stream drops all held records.
- Simultaneous out-drain, skid-full and input: in_ready is 0, so no input is accepted; the skid moves to the output register.

Test Plan:
- Decode, I and S formats: in_instr=0xFFF10093 (addi x1,x2,-1) -> next cycle opcode=0010011, rd=1, rs1=2, funct3=0, imm=0xFFFFFFFF, fmt=1. Then 0x00532423 (sw x5,8(x6)) -> rs1=6, rs2=5, funct3=010, imm=8, fmt=2.
- Decode, B/J/U formats:
  - 0xFE000EE3 -> imm=0xFFFFFFFC, fmt=3.
  - 0x001000EF -> rd=1, imm=0x800, fmt=5.
  - 0x123451B7 -> rd=3, imm=0x12345000, fmt=4.
  - Repeat 0xFE000EE3 with XLEN=64 -> imm=0xFFFFFFFFFFFFFFFC.
- Illegal: in_instr=0x00000000 -> illegal=1, fmt=7, imm=0, out_valid=1. With XLEN=32, 0x0000009B (opcode 0011011) -> illegal=1; with XLEN=64 it gives fmt=1.
- Backpressure: out_ready=0; three back-to-back in_valid words A, B, C -> A and B accepted, in_ready=0 from the cycle after B, C held off. Raise out_ready -> A, B, C delivered in order on consecutive cycles; outputs stable while stalled.
- Flush: hold A in the output register and B in the skid; assert flush with C offered -> next cycle out_valid=0, in_ready=1, C never appears; a following D arrives 1 cycle later.
- Reset mid-stream: assert reset with two records held -> next cycle out_valid=0, all outputs 0, in_ready=1; the first post-reset input appears with 1-cycle latency.
